act_pwl_lut: RTL and testbench

Parametrised piecewise-linear activation unit for the LSTM datapath: replaces the fixed 16-entry sigmoid LUT with a runtime-loadable, two-table (sigmoid/tanh) LUT plus linear interpolation between adjacent entries. It sits between each gate's accumulator output and the cell-state/hidden-state arithmetic. A 3-stage valid/ready pipeline gives full throughput with backpressure.

---
 rtl/act_pwl_lut_if.sv | 34 +++
 rtl/act_pwl_lut.sv | 122 ++++++++++++
 tb/tb_act_pwl_lut.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_pwl_lut_if.sv
// Handshake, table-load and status bundle for act_pwl_lut.
// master = producer/consumer side, slave = the activation unit.
interface act_pwl_lut_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_y;
  logic              tbl_wr;
  logic              tbl_sel;
  logic [ADDR_W-1:0] tbl_addr;
  logic [OUT_W-1:0]  tbl_data;
  logic              busy;

  modport master (
    output in_valid, in_x, in_mode,
    output out_ready,
    output tbl_wr, tbl_sel, tbl_addr, tbl_data,
    input  in_ready, out_valid, out_y, busy
  );

  modport slave (
    input  in_valid, in_x, in_mode,
    input  out_ready,
    input  tbl_wr, tbl_sel, tbl_addr, tbl_data,
    output in_ready, out_valid, out_y, busy
  );
endinterface

// File: rtl/act_pwl_lut.sv
// Piecewise-linear sigmoid/tanh unit: loadable LUT pair plus
// linear interpolation, 3-stage valid/ready pipeline that freezes on stall.
module act_pwl_lut #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  act_pwl_lut_if.slave  bus
);
  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PW     = OUT_W + FRAC_W + 2;

  localparam logic [ADDR_W-1:0] TOP_POS =
    ADDR_W'((1 << (ADDR_W - 1)) - 1);
  localparam logic signed [PW-1:0] YMAX =
    (PW'(1) << (OUT_W - 1)) - PW'(1);
  localparam logic signed [PW-1:0] YMIN = -YMAX - PW'(1);

  typedef logic [OUT_W-1:0] ent_t;

  ent_t t0_q [DEPTH];
  ent_t t1_q [DEPTH];

  logic              v1_q, v2_q, v3_q;
  ent_t              base1_q, next1_q;
  logic [FRAC_W-1:0] frac1_q;
  ent_t              base2_q;
  logic signed [PW-1:0] prod2_q;
  ent_t              y_q;

  logic stall, adv;

  assign stall        = v3_q && !bus.out_ready;
  assign adv          = !stall;
  assign bus.in_ready = adv;
  assign bus.out_valid = v3_q;
  assign bus.out_y    = y_q;
  assign bus.busy     = v1_q | v2_q | v3_q;

  logic [ADDR_W-1:0] addr, addr_n;
  logic [FRAC_W-1:0] frac;
  ent_t              base_d, next_d;

  always_comb begin
    addr   = bus.in_x[DATA_W-1 -: ADDR_W];
    frac   = bus.in_x[FRAC_W-1:0];
    addr_n = addr + ADDR_W'(1);
    base_d = bus.in_mode ? t1_q[addr] : t0_q[addr];
    next_d = '0;
    unique case (1'b1)
      (addr == TOP_POS): next_d = base_d;
      (&addr):
        next_d = bus.in_mode ? t1_q[0] : t0_q[0];
      default:
        next_d = bus.in_mode ? t1_q[addr_n] : t0_q[addr_n];
    endcase
  end

  logic signed [OUT_W:0]  diff;
  logic signed [PW-1:0]   prod_d;

  always_comb begin
    diff   = $signed({next1_q[OUT_W-1], next1_q})
           - $signed({base1_q[OUT_W-1], base1_q});
    prod_d = PW'(diff) * $signed(PW'({1'b0, frac1_q}));
  end

  logic signed [PW-1:0] sum;
  ent_t                 y_d;

  // Arithmetic shift floors, so negative slopes round toward -inf.
  always_comb begin
    sum = $signed(PW'($signed(base2_q))) + (prod2_q >>> FRAC_W);
    y_d = sum[OUT_W-1:0];
    unique case (1'b1)
      (sum > YMAX): y_d = YMAX[OUT_W-1:0];
      (sum < YMIN): y_d = YMIN[OUT_W-1:0];
      default:      y_d = sum[OUT_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        t0_q[i] <= '0;
        t1_q[i] <= '0;
      end
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      base1_q <= '0;
      next1_q <= '0;
      frac1_q <= '0;
      base2_q <= '0;
      prod2_q <= '0;
      y_q     <= '0;
    end else begin
      if (bus.tbl_wr) begin
        if (bus.tbl_sel) t1_q[bus.tbl_addr] <= bus.tbl_data;
        else             t0_q[bus.tbl_addr] <= bus.tbl_data;
      end
      if (adv) begin
        v1_q <= bus.in_valid;
        if (bus.in_valid) begin
          base1_q <= base_d;
          next1_q <= next_d;
          frac1_q <= frac;
        end
        v2_q <= v1_q;
        if (v1_q) begin
          base2_q <= base1_q;
          prod2_q <= prod_d;
        end
        v3_q <= v2_q;
        if (v2_q) y_q <= y_d;
      end
    end
  end
endmodule

// File: tb/tb_act_pwl_lut.sv
// Bench for act_pwl_lut: directed vectors, corner sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_act_pwl_lut;
  logic clk;
  logic rst;

  act_pwl_lut_if #(.DATA_W(8), .ADDR_W(4), .OUT_W(8)) bus ();

  act_pwl_lut #(.DATA_W(8), .ADDR_W(4), .OUT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_out = 0;

  logic signed [7:0] sh [2][16];
  logic signed [7:0] exp_q [$];

  typedef struct {
    logic [7:0] x;
    logic       m;
    int         y;
  } vec_t;

  function automatic int model(input logic [7:0] x, input logic m);
    int a, f, b, n, d, q, y;
    a = int'(x[7:4]);
    f = int'(x[3:0]);
    b = int'(sh[m][a]);
    if (a == 7)       n = b;
    else if (a == 15) n = int'(sh[m][0]);
    else              n = int'(sh[m][a+1]);
    d = (n - b) * f;
    q = d / 16;
    if (d < 0 && (d % 16) != 0) q = q - 1;
    y = b + q;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic signed [7:0] e;
    if (!rst) begin
      exp_q.delete();
      for (int s = 0; s < 2; s++)
        for (int a = 0; a < 16; a++) sh[s][a] = '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard: unexpected y=%0d, none queued",
                   $signed(bus.out_y));
        end else begin
          e = exp_q.pop_front();
          if ($signed(bus.out_y) !== e) begin
            n_bad++;
            $display("FAIL scoreboard: got %0d, want %0d",
                     $signed(bus.out_y), e);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(8'(model(bus.in_x, bus.in_mode)));
      if (bus.tbl_wr) sh[bus.tbl_sel][bus.tbl_addr] = bus.tbl_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tw(input logic s, input logic [3:0] a,
                    input logic [7:0] d);
    bus.tbl_wr   = 1'b1;
    bus.tbl_sel  = s;
    bus.tbl_addr = a;
    bus.tbl_data = d;
    tick();
    bus.tbl_wr = 1'b0;
  endtask

  task automatic wait_out(output int y, output int ok);
    ok = 0;
    y  = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) begin
        ok = 1;
        y  = $signed(bus.out_y);
        break;
      end
      tick();
    end
  endtask

  task automatic run_one(input logic [7:0] x, input logic m,
                         input int exp, input string nm);
    int lat;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_mode  = m;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, lat, 3);
    chk(nm, $signed(bus.out_y), exp);
    tick();
  endtask

  task automatic drain(input string nm);
    int c = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.tbl_wr    = 1'b0;
    while ((exp_q.size() != 0 || bus.busy) && c < 50) begin
      tick();
      c++;
    end
    chk(nm, int'(exp_q.size() != 0 || bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v [8];
    int   sig [16];
    logic [7:0] xs [6];
    int   y, ok, n0, sent, stall_n, held;
    bit   acc;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    bus.tbl_wr    = 1'b0;
    bus.tbl_sel   = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_data  = '0;

    #2;
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset out_y", int'(bus.out_y), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("in_ready after reset", int'(bus.in_ready), 1);
    tick();

    sig = '{8, 11, 14, 15, 15, 15, 15, 15, 0, 0, 0, 0, 0, 0, 1, 4};
    for (int i = 0; i < 16; i++) tw(1'b0, 4'(i), 8'(sig[i]));
    tw(1'b1, 4'd1, 8'd20);
    tw(1'b1, 4'd2, 8'd40);

    v[0] = '{8'h00, 1'b0, 8};
    v[1] = '{8'h08, 1'b0, 9};
    v[2] = '{8'h18, 1'b0, 12};
    v[3] = '{8'h80, 1'b0, 0};
    v[4] = '{8'h7F, 1'b0, 15};
    v[5] = '{8'hF8, 1'b0, 6};
    v[6] = '{8'hF0, 1'b0, 4};
    v[7] = '{8'h18, 1'b1, 30};
    for (int i = 0; i < 8; i++)
      run_one(v[i].x, v[i].m, v[i].y, $sformatf("vec%0d", i));

    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = ((i % 4) < 2) ? 8'h18 : 8'h08;
      bus.in_mode  = 1'(i % 2);
      tick();
    end
    drain("interleave drain");
    chk("interleave count", n_out - n0, 8);

    for (int i = 0; i < 6; i++) xs[i] = 8'($urandom);
    n0      = n_out;
    sent    = 0;
    stall_n = 0;
    held    = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.in_valid  = (sent < 6);
      bus.in_x      = (sent < 6) ? xs[sent] : 8'h00;
      bus.in_mode   = 1'b0;
      bus.out_ready = !(cyc >= 4 && cyc <= 8);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall in_ready", int'(bus.in_ready), 0);
        if (stall_n == 0) held = int'(bus.out_y);
        else chk("stall hold out_y", int'(bus.out_y), held);
        stall_n++;
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) sent++;
    end
    chk("stall cycles", stall_n, 5);
    drain("backpressure drain");
    chk("backpressure count", n_out - n0, 6);

    bus.in_valid = 1'b1;
    bus.in_x     = 8'h00;
    bus.in_mode  = 1'b0;
    bus.tbl_wr   = 1'b1;
    bus.tbl_sel  = 1'b0;
    bus.tbl_addr = 4'd0;
    bus.tbl_data = 8'd50;
    tick();
    bus.tbl_wr = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    wait_out(y, ok);
    chk("race first valid", ok, 1);
    chk("race pre-write", y, 8);
    tick();
    wait_out(y, ok);
    chk("race second valid", ok, 1);
    chk("race post-write", y, 50);
    tick();
    drain("race drain");

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++) tw(1'(s), 4'(a), 8'($urandom));
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_x      = 8'($urandom);
      bus.in_mode   = 1'($urandom);
      bus.out_ready = ($urandom % 4) != 0;
      bus.tbl_wr    = ($urandom % 8) == 0;
      bus.tbl_sel   = 1'($urandom);
      bus.tbl_addr  = 4'($urandom);
      bus.tbl_data  = 8'($urandom);
      tick();
    end
    drain("random drain");

    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 8'($urandom);
      bus.in_mode  = 1'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("inflight busy", int'(bus.busy), 1);
    chk("inflight out_valid", int'(bus.out_valid), 1);
    rst = 1'b0;
    #1;
    chk("async rst out_valid", int'(bus.out_valid), 0);
    chk("async rst busy", int'(bus.busy), 0);
    chk("async rst out_y", int'(bus.out_y), 0);
    tick();
    rst = 1'b1;
    tick();
    run_one(8'h00, 1'b0, 0, "cleared sig");
    run_one(8'hF8, 1'b1, 0, "cleared tanh");
    drain("final drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
